// File: rtl/io_out_arbiter.sv
// Four 1-entry output port buffers drained round-robin to one slow device over valid/ready.
// Define IO_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (port 0 highest).
module io_out_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ovf_clr,
  output logic              dev_valid,
  output logic [DATA_W-1:0] dev_data,
  output logic [1:0]        dev_port,
  input  logic              dev_ready,
  output logic [3:0]        pending,
  output logic [3:0]        overflow
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e            state_q, state_d;
  logic              dev_valid_q, dev_valid_d;
  logic [DATA_W-1:0] dev_data_q, dev_data_d;
  logic [1:0]        dev_port_q, dev_port_d;
  logic [1:0]        last_grant_q, last_grant_d;
  logic [3:0]        pending_q, pending_d;
  logic [3:0]        overflow_q, overflow_d;
  logic [DATA_W-1:0] data_buf_q [4];
  logic [DATA_W-1:0] data_buf_d [4];

  logic       handshake;
  logic [3:0] hs_mask;
  logic [3:0] drop;
  logic [3:0] accept;
  logic [1:0] grant;

  // Scan last+1 .. last+4 (mod 4); iterating backwards lets the first hit in scan order win.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [1:0] fixed_pick(input logic [3:0] req);
    fixed_pick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) fixed_pick = 2'(i);
    end
  endfunction

  always_comb begin
    handshake = (state_q == SEND) && dev_ready;
    hs_mask   = handshake ? (4'b0001 << dev_port_q) : 4'b0000;
    // A port being drained this edge can take a new word without loss.
    drop       = wr_en & pending_q & ~hs_mask;
    accept     = wr_en & ~drop;
    pending_d  = accept | (pending_q & ~hs_mask);
    overflow_d = (ovf_clr ? 4'b0000 : overflow_q) | drop;
    for (int p = 0; p < 4; p++) begin
      data_buf_d[p] = accept[p] ? wr_data : data_buf_q[p];
    end

`ifdef IO_ARB_FIXED_PRIO_EN
    grant = fixed_pick(pending_q);
`else
    grant = rr_pick(pending_q, last_grant_q);
`endif

    state_d      = state_q;
    dev_valid_d  = dev_valid_q;
    dev_data_d   = dev_data_q;
    dev_port_d   = dev_port_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          dev_data_d  = data_buf_q[grant];
          dev_port_d  = grant;
          dev_valid_d = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (dev_ready) begin
          dev_valid_d  = 1'b0;
          last_grant_d = dev_port_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      dev_valid_q  <= 1'b0;
      dev_data_q   <= '0;
      dev_port_q   <= 2'd0;
      last_grant_q <= 2'd3;
      pending_q    <= 4'b0000;
      overflow_q   <= 4'b0000;
    end else begin
      state_q      <= state_d;
      dev_valid_q  <= dev_valid_d;
      dev_data_q   <= dev_data_d;
      dev_port_q   <= dev_port_d;
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
    end
  end

  // Buffer contents are only meaningful while pending, so they carry no reset.
  always_ff @(posedge clock) begin
    for (int p = 0; p < 4; p++) begin
      data_buf_q[p] <= data_buf_d[p];
    end
  end

  assign dev_valid = dev_valid_q;
  assign dev_data  = dev_data_q;
  assign dev_port  = dev_port_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule
